// File: rtl/ysyx_25030081_lsu.sv
// Load/store unit for the NPC execute path.
// Takes one memory op at a time (effective address from the ALU), issues a
// single valid/ready request with lane-shifted store data and strobes, and
// returns sign/zero-extended load data to write-back. Misaligned or illegal
// ops are reported with out_err and never reach the memory port.
module ysyx_25030081_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_wdata,
  input  logic                  in_wen,
  input  logic [2:0]            in_funct3,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wen,
  output logic [3:0]            mem_wmask,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_rdata,
  output logic                  out_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic        accept;
  logic        bad_op;
  logic        misaligned;
  logic        reject;

  // Byte strobes for a store; the width lives in funct3[1:0].
  function automatic logic [3:0] store_mask(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'd0:    store_mask = 4'b0001 << off;
      2'd1:    store_mask = 4'b0011 << off;
      2'd2:    store_mask = 4'b1111;
      default: store_mask = 4'b0000;
    endcase
  endfunction

  // Store data replicated across every lane, so the strobe alone picks the byte(s).
  function automatic logic [DATA_WIDTH-1:0] store_data(input logic [2:0] f3,
                                                       input logic [DATA_WIDTH-1:0] wd);
    case (f3[1:0])
      2'd0:    store_data = {4{wd[7:0]}};
      2'd1:    store_data = {2{wd[15:0]}};
      default: store_data = wd;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0 and extend according to funct3.
  function automatic logic [DATA_WIDTH-1:0] load_format(input logic [DATA_WIDTH-1:0] raw,
                                                        input logic [1:0] off,
                                                        input logic [2:0] f3);
    logic [DATA_WIDTH-1:0] w;
    w = raw >> {off, 3'b000};
    case (f3)
      3'd0:    load_format = {{(DATA_WIDTH-8){w[7]}}, w[7:0]};
      3'd1:    load_format = {{(DATA_WIDTH-16){w[15]}}, w[15:0]};
      3'd4:    load_format = {{(DATA_WIDTH-8){1'b0}}, w[7:0]};
      3'd5:    load_format = {{(DATA_WIDTH-16){1'b0}}, w[15:0]};
      default: load_format = w;
    endcase
  endfunction

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);

  assign accept     = in_ready && in_valid;
  // Stores only have widths 0..2; loads reject 3, 6 and 7.
  assign bad_op     = in_wen ? (in_funct3 > 3'd2)
                             : ((in_funct3 == 3'd3) || (in_funct3[2:1] == 2'b11));
  assign misaligned = ((in_funct3[1:0] == 2'd1) && in_addr[0]) ||
                      ((in_funct3[1:0] == 2'd2) && (in_addr[1:0] != 2'b00));
  assign reject     = bad_op || misaligned;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: rejected ops jump straight to DONE, others walk the memory handshake.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid) state_next = reject ? DONE : REQ;
      REQ:     if (mem_req_ready) state_next = WAIT;
      WAIT:    if (mem_rsp_valid) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request fields latched at accept and result captured on the response;
  // all outputs come straight from these registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      funct3_q  <= 3'd0;
      off_q     <= 2'd0;
      mem_addr  <= '0;
      mem_wen   <= 1'b0;
      mem_wmask <= 4'b0000;
      mem_wdata <= '0;
      out_rdata <= '0;
      out_err   <= 1'b0;
    end else begin
      if (accept) begin
        funct3_q  <= in_funct3;
        off_q     <= in_addr[1:0];
        out_rdata <= '0;
        out_err   <= reject;
        if (!reject) begin
          mem_addr  <= {in_addr[ADDR_WIDTH-1:2], 2'b00};
          mem_wen   <= in_wen;
          mem_wmask <= in_wen ? store_mask(in_funct3, in_addr[1:0]) : 4'b0000;
          mem_wdata <= in_wen ? store_data(in_funct3, in_wdata) : '0;
        end
      end
      if ((state == WAIT) && mem_rsp_valid) begin
        out_rdata <= mem_wen ? '0 : load_format(mem_rdata, off_q, funct3_q);
      end
    end
  end

endmodule

// File: tb/tb_ysyx_25030081_lsu.sv
// Randomized bench for the LSU: a transaction-level model predicts each op's
// memory request, result and latency; one negedge process compares every cycle.
module tb_ysyx_25030081_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_wen;
  logic [31:0] in_addr, in_wdata;
  logic [2:0]  in_funct3;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_rdata;

  ysyx_25030081_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_wdata(in_wdata), .in_wen(in_wen), .in_funct3(in_funct3),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
    .out_err(out_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Expected transaction (model output)
  logic        e_err, e_wen;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_mask;
  int          e_lat;

  // Transaction tracking shared between driver and checker
  bit cur_active = 0, req_pending = 0, seen_out = 0;
  int ncount = 0, acc_n = 0, n_done = 0;
  logic [31:0] last_rdata, last_wdata, last_addr;
  logic [3:0]  last_wmask;
  logic        last_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: what the memory port and result must be for one op.
  task automatic predict(input logic [31:0] a, input logic [31:0] wd, input logic w,
                         input logic [2:0] f3, input logic [31:0] rd);
    int size, off;
    bit uns, legal;
    longint v;
    off = int'(a[1:0]);
    uns = 0; legal = 1; size = 4;
    case (f3)
      3'd0: size = 1;
      3'd1: size = 2;
      3'd2: size = 4;
      3'd4: begin size = 1; uns = 1; end
      3'd5: begin size = 2; uns = 1; end
      default: legal = 0;
    endcase
    if (w && f3 > 3'd2) legal = 0;
    e_err  = !legal || ((off % size) != 0);
    e_addr = a & ~32'd3;
    e_wen  = w;
    e_mask = 4'b0000; e_wdata = 32'd0; e_rdata = 32'd0;
    if (!e_err && w) begin
      for (int i = 0; i < 4; i++) begin
        if (i >= off && i < off + size) e_mask[i] = 1'b1;
        e_wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      end
    end
    if (!e_err && !w) begin
      v = longint'(rd >> (8*off)) & ((64'd1 << (8*size)) - 64'd1);
      if (!uns && v >= (64'd1 << (8*size-1))) v = v - (64'd1 << (8*size));
      e_rdata = v[31:0];
    end
  endtask

  // Per-cycle checker.
  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready, !cur_active);
      chk("mem_req_valid", mem_req_valid, req_pending);
      if (mem_req_valid && req_pending) begin
        chk("mem_addr", mem_addr, e_addr);
        chk("mem_wen", mem_wen, e_wen);
        chk("mem_wmask", mem_wmask, e_mask);
        if (e_wen) chk("mem_wdata", mem_wdata, e_wdata);
        last_addr = mem_addr; last_wmask = mem_wmask; last_wdata = mem_wdata;
      end
      if (out_valid) begin
        chk("out_valid_in_txn", cur_active, 1'b1);
        chk("out_rdata", out_rdata, e_rdata);
        chk("out_err", out_err, e_err);
        last_rdata = out_rdata; last_err = out_err;
        if (!seen_out) begin
          seen_out = 1;
          chk("latency", ncount - acc_n + 1, e_lat);
        end
        if (out_ready) n_done++;
      end else if (seen_out && cur_active) begin
        chk("out_valid_hold", out_valid, 1'b1);
      end
    end
    ncount++;
  end

  task automatic accept_op(input logic [31:0] a, input logic [31:0] wd, input logic w,
                           input logic [2:0] f3, input logic [31:0] rd,
                           input int req_d, input int rsp_d);
    predict(a, wd, w, f3, rd);
    in_addr = a; in_wdata = wd; in_wen = w; in_funct3 = f3; in_valid = 1'b1;
    @(posedge clk);
    cur_active = 1; req_pending = !e_err; seen_out = 0; acc_n = ncount;
    e_lat = e_err ? 1 : 3 + req_d + rsp_d;
    #1;
    in_valid = 1'b0; in_addr = $urandom; in_wdata = $urandom;
    in_wen = 1'($urandom); in_funct3 = 3'($urandom);
  endtask

  task automatic req_phase(input int req_d);
    bit fired = 0;
    int k = 0;
    while (!fired && k < 64) begin
      mem_req_ready = (k >= req_d);
      @(negedge clk);
      fired = mem_req_valid && mem_req_ready;
      @(posedge clk);
      if (fired) req_pending = 0;
      #1;
      k++;
    end
    mem_req_ready = 1'b0;
    if (!fired) chk("req_handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] wd, input logic w,
                        input logic [2:0] f3, input logic [31:0] rd,
                        input int req_d, input int rsp_d, input int out_d);
    bit fired;
    int k, held;
    accept_op(a, wd, w, f3, rd, req_d, rsp_d);
    if (!e_err) begin
      req_phase(req_d);
      repeat (rsp_d) begin @(posedge clk); #1; end
      mem_rdata = rd; mem_rsp_valid = 1'b1;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0; mem_rdata = $urandom;
    end
    fired = 0; k = 0; held = 0;
    while (!fired && k < 64) begin
      out_ready = (held >= out_d);
      @(negedge clk);
      if (out_valid) begin fired = out_ready; held++; end
      @(posedge clk);
      if (fired) cur_active = 0;
      #1;
      k++;
    end
    out_ready = 1'b0;
    if (!fired) begin
      chk("out_handshake_timeout", 32'd0, 32'd1);
      cur_active = 0; req_pending = 0;
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0;
    logic [31:0] a;
    rst = 1'b1; in_valid = 0; in_addr = 0; in_wdata = 0; in_wen = 0; in_funct3 = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_req_valid", mem_req_valid, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases with hand-computed results
    run_op(32'h80000003, 32'h0, 1'b0, 3'd0, 32'h80FF1234, 0, 0, 0);
    chk("lb_addr", last_addr, 32'h80000000);
    chk("lb_wmask", last_wmask, 4'b0000);
    chk("lb_rdata", last_rdata, 32'hFFFFFF80);
    chk("lb_err", last_err, 1'b0);
    run_op(32'h80000002, 32'h0, 1'b0, 3'd5, 32'hBEEF0000, 0, 0, 0);
    chk("lhu_rdata", last_rdata, 32'h0000BEEF);
    run_op(32'h80000002, 32'h0, 1'b0, 3'd1, 32'hBEEF0000, 0, 1, 0);
    chk("lh_rdata", last_rdata, 32'hFFFFBEEF);
    run_op(32'h80000001, 32'h000000AB, 1'b1, 3'd0, 32'h12345678, 0, 0, 0);
    chk("sb_wmask", last_wmask, 4'b0010);
    chk("sb_wdata", last_wdata, 32'hABABABAB);
    chk("sb_rdata", last_rdata, 32'd0);
    run_op(32'h80000002, 32'h0, 1'b0, 3'd2, 32'h0, 0, 0, 0);
    chk("lw_misaligned_err", last_err, 1'b1);
    chk("lw_misaligned_rdata", last_rdata, 32'd0);
    run_op(32'h80000004, 32'h0, 1'b0, 3'd3, 32'h0, 0, 0, 0);
    chk("ld_f3_3_err", last_err, 1'b1);

    // Back-pressure on both sides: one store, held fields checked every cycle
    d0 = n_done;
    run_op(32'h80000008, 32'hCAFEF00D, 1'b1, 3'd2, 32'h0, 5, 0, 3);
    chk("bp_wmask", last_wmask, 4'b1111);
    chk("bp_wdata", last_wdata, 32'hCAFEF00D);
    chk("bp_one_done", n_done - d0, 1);

    // Asynchronous reset while waiting for the load response
    accept_op(32'h80000010, 32'h0, 1'b0, 3'd2, 32'h11112222, 0, 0);
    req_phase(0);
    #2 rst = 1'b1;
    #1;
    cur_active = 0; req_pending = 0;
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_req_valid", mem_req_valid, 1'b0);
    chk("arst_mem_wen", mem_wen, 1'b0);
    chk("arst_mem_wmask", mem_wmask, 4'b0000);
    chk("arst_mem_addr", mem_addr, 32'd0);
    chk("arst_mem_wdata", mem_wdata, 32'd0);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_out_rdata", out_rdata, 32'd0);
    chk("arst_out_err", out_err, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    mem_rdata = 32'hDEADBEEF; mem_rsp_valid = 1'b1;
    @(posedge clk); #1;
    mem_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_out_valid", out_valid, 1'b0);
    run_op(32'h80000010, 32'h0, 1'b0, 3'd2, 32'h11112222, 0, 0, 0);
    chk("post_rst_lw", last_rdata, 32'h11112222);

    // Randomized ops
    for (int i = 0; i < 200; i++) begin
      a = 32'h80000000 + ($urandom & 32'hFF);
      run_op(a, $urandom, 1'($urandom), 3'($urandom), $urandom,
             ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
             ($urandom_range(0, 2) == 0) ? $urandom_range(0, 4) : 0,
             ($urandom_range(0, 2) == 0) ? $urandom_range(0, 3) : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_25030081_lsu.md
# ysyx_25030081_lsu

Load/store unit sitting directly downstream of the ALU in the NPC execute path. Accepts a memory operation whose effective address is the ALU `out` result (rs1 + imm), issues a single request on a simple valid/ready memory port, and returns load data aligned and sign/zero-extended to the write-back stage. It handles one transaction at a time, and reports misaligned or illegal-width accesses without touching memory.

## Interface
Parameters:
- `DATA_WIDTH`, 32: data width. Only 32 is supported.
- `ADDR_WIDTH`, 32: address width.

Ports:
- `clk`  in  1  clock. The block has one clock; all state updates on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `in_valid`  in  1  execute stage presents a memory op.
- `in_ready`  out  1  LSU can accept; equals (state == IDLE).
- `in_addr`  in  ADDR_WIDTH  effective address from the ALU.
- `in_wdata`  in  DATA_WIDTH  rs2 value, used for stores.
- `in_wen`  in  1  1 = store, 0 = load.
- `in_funct3`  in  3  RISC-V funct3 (LB 0, LH 1, LW 2, LBU 4, LHU 5; SB 0, SH 1, SW 2).
- `mem_req_valid`  out  1  request valid.
- `mem_req_ready`  in  1  memory accepts request.
- `mem_addr`  out  ADDR_WIDTH  word-aligned address {addr[31:2], 2'b00}.
- `mem_wen`  out  1  store request.
- `mem_wmask`  out  4  byte-lane write strobes.
- `mem_wdata`  out  DATA_WIDTH  lane-shifted store data.
- `mem_rsp_valid`  in  1  response or store acknowledge.
- `mem_rdata`  in  DATA_WIDTH  raw word read.
- `out_valid`  out  1  result available to write-back.
- `out_ready`  in  1  write-back consumes the result.
- `out_rdata`  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- `out_err`  out  1  misaligned or illegal funct3; no memory access was made.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- **IDLE:** `in_ready`=1. On `in_valid`, the block latches addr, wdata, wen and funct3. It then runs a check:
  - Illegal op: load funct3 of 3, 6 or 7; store funct3 greater than 2.
  - Misaligned: halfword access with addr[0]=1; word access with addr[1:0]≠0.
  - Illegal or misaligned goes to DONE with `err`=1 and `rdata`=0. Otherwise go to REQ.
- **REQ:** `mem_req_valid`=1. addr, wen, wmask and wdata are held stable until `mem_req_ready`, then go to WAIT. Waiting in REQ is unbounded.
- **WAIT:** on `mem_rsp_valid`, capture the formatted result into the output register and go to DONE. `mem_rsp_valid` in any other state is ignored.
- **DONE:** `out_valid`=1, with rdata and err held stable, until `out_ready`, then go to IDLE.
- Store lanes, with sh = addr[1:0]×8:
  - SB: wmask = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: wmask = 4'b0011 << addr[1:0]; wdata = {2{wdata[15:0]}}.
  - SW: wmask = 4'b1111; wdata unchanged.
- Loads: let `w` = mem_rdata >> sh.
  - LB: sign-extend w[7:0].
  - LBU: zero-extend w[7:0].
  - LH: sign-extend w[15:0].
  - LHU: zero-extend w[15:0].
  - LW: w.
- A store completes when `mem_rsp_valid` arrives, with `out_rdata`=0.
- For loads, `mem_wmask`=0 and `mem_wen`=0.

## Timing
- Reset (asynchronous, mid-transaction included): state goes to IDLE immediately. Outputs:
  - `in_ready`=1.
  - `mem_req_valid`=0, `mem_wen`=0, `mem_wmask`=0, `mem_addr`=0, `mem_wdata`=0.
  - `out_valid`=0, `out_rdata`=0, `out_err`=0.
  - Any response arriving after reset is ignored.
- Best-case load/store latency, with accept at cycle T:
  - `mem_req_valid` asserts at T+1.
  - With ready at T+1, the response is taken no earlier than T+2.
  - `out_valid` asserts at T+3.
- Error path: accept at T, `out_valid`/`out_err` at T+1.
- `in_ready` is registered-state-derived only; there is no combinational path from `out_ready` to `in_ready`. A new op is accepted no earlier than the cycle after the DONE handshake.
- All memory-side and output signals are driven from registers, so there is no combinational path from inputs to outputs.
- `mem_req_valid` never deasserts before `mem_req_ready`. `out_valid` never deasserts before `out_ready`.

## Test plan
- LB at addr 0x80000003, mem_rdata 0x80FF1234 -> mem_addr 0x80000000, wmask 0, out_rdata 0xFFFFFF80, err 0.
- LHU at 0x80000002, mem_rdata 0xBEEF0000 -> out_rdata 0x0000BEEF. LH at the same address -> 0xFFFFBEEF.
- SB at 0x80000001, wdata 0x000000AB -> wmask 4'b0010, mem_wdata 0xABABABAB, out_rdata 0 after the ack.
- LW at 0x80000002 -> no `mem_req_valid` ever, `out_valid`+`out_err` at T+1; load funct3=3 -> same.
- Back-pressure: hold `mem_req_ready`=0 for 5 cycles and `out_ready`=0 for 3 cycles -> req fields and out fields stay stable, `in_ready` stays 0 throughout, and exactly one transaction completes.
- Assert `rst` while in WAIT, then deliver `mem_rsp_valid` after reset -> state IDLE, `out_valid` stays 0, and the next LW completes normally.
